// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and line constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS              = 8;
    localparam int UART_DEFAULT_CLOCKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period cycle counter with clear and last-cycle flag
module uart_bit_timer #(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic last_cycle
);

    localparam int W = (CLOCKS_PER_BIT < 2) ? 1 : $clog2(CLOCKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLOCKS_PER_BIT - 1);

    if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_bit_timer: CLOCKS_PER_BIT must be at least 2");
    end

    logic [W-1:0] count;

    // Only an explicit clear returns the counter to zero; the owner clears on last_cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign last_cycle = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - drains a fall-through FIFO into 8N1 UART frames on tx
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = UART_DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_read_data,
    output logic       fifo_read_enable,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_count;
    logic                      last_cycle;
    logic                      timer_clear;

    // The FIFO has no underflow guard, so the pop is qualified by empty and reset here.
    assign fifo_read_enable = (state == IDLE) && !fifo_empty && reset_n;
    assign busy             = (state != IDLE) && reset_n;
    assign timer_clear      = (state == IDLE) || last_cycle;

    uart_bit_timer #(
        .CLOCKS_PER_BIT(clocks_per_bit)
    ) u_bit_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (timer_clear),
        .last_cycle(last_cycle)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            bit_count <= 3'd0;
            shift     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_read_enable) begin
                        shift <= fifo_read_data;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (last_cycle) begin
                        tx        <= shift[0];
                        shift     <= shift >> 1;
                        bit_count <= 3'd0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (last_cycle) begin
                        if (bit_count == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx        <= shift[0];
                            shift     <= shift >> 1;
                            bit_count <= bit_count + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (last_cycle) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - scoreboard bench for uart_tx_drain at 4 and 2 clocks per bit
module tb_uart_tx_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [2] = '{1'b0, 1'b0};
    logic       empty_s [2] = '{1'b1, 1'b1};
    logic [7:0] data_s  [2] = '{8'h00, 8'h00};
    logic       push_v  [2] = '{1'b0, 1'b0};
    logic [7:0] push_d  [2] = '{8'h00, 8'h00};
    logic       rd_s    [2];
    logic       tx_s    [2];
    logic       busy_s  [2];

    logic [7:0] fifo_q [2][$];
    logic [7:0] exp_q  [2][$];

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    bit fin  = 1'b0;

    uart_tx_drain #(.clocks_per_bit(4)) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .fifo_empty(empty_s[0]), .fifo_read_data(data_s[0]),
        .fifo_read_enable(rd_s[0]), .tx(tx_s[0]), .busy(busy_s[0])
    );

    uart_tx_drain #(.clocks_per_bit(2)) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .fifo_empty(empty_s[1]), .fifo_read_data(data_s[1]),
        .fifo_read_enable(rd_s[1]), .tx(tx_s[1]), .busy(busy_s[1])
    );

    // Fall-through FIFO model: head and empty flag update just after the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_s[i] && fifo_q[i].size() > 0) fifo_q[i].delete(0);
            if (push_v[i]) fifo_q[i].push_back(push_d[i]);
            empty_s[i] <= (fifo_q[i].size() == 0);
            data_s[i]  <= (fifo_q[i].size() > 0) ? fifo_q[i][0] : 8'h00;
        end
    end

    function automatic int cpb_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic chk(input bit ok, input string name, input int i,
                       input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, i, $time, act, req);
        end
    endtask

    int         k         [2] = '{0, 0};
    bit         active    [2] = '{1'b0, 1'b0};
    bit         post_rst  [2] = '{1'b0, 1'b0};
    bit         glitch    [2] = '{1'b0, 1'b0};
    bit         frame_bad [2] = '{1'b0, 1'b0};
    logic [9:0] obs       [2] = '{10'h3ff, 10'h3ff};
    int         pops      [2] = '{0, 0};
    int         frames    [2] = '{0, 0};

    always @(negedge clk) begin
        int f;
        int b;
        logic [7:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            f = 10 * cpb_of(i);
            if (!rst_n[i]) begin
                chk(!busy_s[i] && !rd_s[i], "reset_gate", i, {14'd0, busy_s[i], rd_s[i]}, 16'h0);
                active[i]   = 1'b0;
                post_rst[i] = 1'b1;
            end else begin
                if (post_rst[i]) begin
                    chk(tx_s[i] && !busy_s[i], "post_reset", i, {14'd0, tx_s[i], busy_s[i]}, 16'h2);
                    post_rst[i] = 1'b0;
                end
                chk(!(rd_s[i] && empty_s[i]), "no_underflow", i, {14'd0, rd_s[i], empty_s[i]}, 16'h0);
                if (active[i] && k[i] < f) begin
                    k[i]++;
                    b = (k[i] - 1) / cpb_of(i);
                    if ((k[i] - 1) % cpb_of(i) == 0) obs[i][b] = tx_s[i];
                    else if (tx_s[i] != obs[i][b]) glitch[i] = 1'b1;
                    if (!busy_s[i] || rd_s[i]) frame_bad[i] = 1'b1;
                    if (k[i] == f) begin
                        if (exp_q[i].size() > 0) begin
                            e = exp_q[i].pop_front();
                        end else begin
                            e = 8'h00;
                            chk(1'b0, "unexpected_frame", i, {6'd0, obs[i]}, 16'h0);
                        end
                        chk(!glitch[i] && obs[i] == {1'b1, e, 1'b0}, "frame", i,
                            {5'd0, glitch[i], obs[i]}, {6'd0, 1'b1, e, 1'b0});
                        chk(!frame_bad[i], "busy_no_pop_in_frame", i, {15'd0, frame_bad[i]}, 16'h0);
                        frames[i]++;
                    end
                end else begin
                    chk(tx_s[i] && !busy_s[i], "idle_line", i, {14'd0, tx_s[i], busy_s[i]}, 16'h2);
                    if (active[i]) begin
                        // First idle cycle after a frame: pop exactly when data is waiting.
                        chk(rd_s[i] == !empty_s[i], "pop_gap", i, {15'd0, rd_s[i]}, {15'd0, !empty_s[i]});
                        active[i] = 1'b0;
                    end
                    if (rd_s[i]) begin
                        active[i]    = 1'b1;
                        k[i]         = 0;
                        glitch[i]    = 1'b0;
                        frame_bad[i] = 1'b0;
                        obs[i]       = 10'h3ff;
                        pops[i]++;
                    end
                end
            end
        end
        if (done && !fin) begin
            chk(exp_q[0].size() == 0, "exp_drained", 0, 16'(exp_q[0].size()), 16'd0);
            chk(exp_q[1].size() == 0, "exp_drained", 1, 16'(exp_q[1].size()), 16'd0);
            chk(pops[0] == 6, "pop_count", 0, 16'(pops[0]), 16'd6);
            chk(pops[1] == 2, "pop_count", 1, 16'(pops[1]), 16'd2);
            chk(frames[0] == 5, "frame_count", 0, 16'(frames[0]), 16'd5);
            chk(frames[1] == 2, "frame_count", 1, 16'(frames[1]), 16'd2);
            chk(empty_s[0] && empty_s[1], "fifo_empty_end", 0, {14'd0, empty_s[0], empty_s[1]}, 16'h3);
            fin = 1'b1;
        end
    end

    task automatic push(input int i, input logic [7:0] val, input bit expect_out);
        push_v[i] = 1'b1;
        push_d[i] = val;
        if (expect_out) exp_q[i].push_back(val);
        @(negedge clk);
        push_v[i] = 1'b0;
    endtask

    task automatic wait_pop(input int i);
        for (int n = 0; n < 300 && !rd_s[i]; n++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (200) @(negedge clk);

        push(0, 8'hA5, 1'b1);
        repeat (50) @(negedge clk);

        push(0, 8'h00, 1'b1);
        push(0, 8'hFF, 1'b1);
        push(0, 8'h3C, 1'b1);
        repeat (140) @(negedge clk);

        // 0x81 is aborted by a one-cycle reset during its data bit 3 (cycles T+17..T+20).
        push(0, 8'h81, 1'b0);
        wait_pop(0);
        push(0, 8'h55, 1'b1);
        repeat (16) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (60) @(negedge clk);

        push(1, 8'hAA, 1'b1);
        push(1, 8'h55, 1'b1);
        repeat (60) @(negedge clk);

        done = 1'b1;
        for (int n = 0; n < 10 && !fin; n++) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
